// File: rtl/sweep_sequencer.sv
// Amplitude-frequency sweep sequencer: steps the DDS word, derives sample-clock settings,
// waits settle/Vpp detection and writes results. Define LOG_SWEEP_EN for a geometric sweep.
module sweep_sequencer #(
  parameter int unsigned SETTLE_CYC  = 10000,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter logic [31:0] RT_KW_MAX   = 32'h0010_624E,
  parameter int unsigned RT_SHIFT    = 5,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      kw_start,
  input  logic [31:0]      kw_step,
  input  logic [IDX_W-1:0] n_points,
  input  logic [31:0]      kw_eqv_dlt,
  input  logic [31:0]      times_eqv,
  input  logic [11:0]      vpp,
  input  logic             vpp_found,
  output logic [31:0]      fre_kw,
  output logic [31:0]      samp_kw,
  output logic [31:0]      times,
  output logic             vpp_clr,
  output logic             res_we,
  output logic [IDX_W-1:0] res_addr,
  output logic [12:0]      res_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ARM, WAIT, STORE, NEXT, DONE} state_t;

  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam int unsigned WIDE_W       = 32 + RT_SHIFT;

  state_t           state, state_nx;
  logic [2:0]       sync;
  logic             found_rise;
  logic [31:0]      cnt;
  logic [31:0]      kw;
  logic [31:0]      step_lat, dlt_lat, teqv_lat;
  logic [IDX_W-1:0] n_lat, idx, n_last;
  logic             flag;

  function automatic logic [31:0] sat_shl(input logic [31:0] k);
    logic [WIDE_W-1:0] wide;
    wide = {{RT_SHIFT{1'b0}}, k} << RT_SHIFT;
    return (|wide[WIDE_W-1:32]) ? 32'hFFFF_FFFF : wide[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'h0;
  endfunction

  function automatic logic [31:0] next_kw(input logic [31:0] k, input logic [31:0] s);
`ifdef LOG_SWEEP_EN
    logic [31:0] inc;
    inc = k >> s[4:0];
    if (inc == 32'h0) inc = 32'h1;
    return k + inc;
`else
    return k + s;
`endif
  endfunction

  // Two-flop synchroniser for the detector flag, third flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b000;
    else        sync <= {sync[1:0], vpp_found};
  end
  assign found_rise = sync[1] & ~sync[2];
  assign n_last     = n_lat - IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    vpp_clr  = 1'b0;
    res_we   = 1'b0;
    res_addr = idx;
    res_data = 13'h0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = (n_points != '0) ? LOAD : DONE;
        LOAD:    state_nx = SETTLE;
        SETTLE:  if (cnt == SETTLE_LAST) state_nx = ARM;
        ARM: begin
          vpp_clr  = 1'b1;
          state_nx = WAIT;
        end
        WAIT:    if (found_rise || cnt == TIMEOUT_LAST) state_nx = STORE;
        STORE: begin
          res_we   = 1'b1;
          res_data = {flag, flag ? 12'h000 : vpp};
          state_nx = NEXT;
        end
        NEXT:    state_nx = (idx == n_last) ? DONE : LOAD;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Latched sweep setup, per-point datapath and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fre_kw   <= '0;
      samp_kw  <= '0;
      times    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      kw       <= '0;
      step_lat <= '0;
      dlt_lat  <= '0;
      teqv_lat <= '0;
      n_lat    <= '0;
      idx      <= '0;
      flag     <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          kw       <= kw_start;
          step_lat <= kw_step;
          dlt_lat  <= kw_eqv_dlt;
          teqv_lat <= times_eqv;
          n_lat    <= n_points;
          idx      <= '0;
          done     <= 1'b0;
          busy     <= (n_points != '0);
        end
        LOAD: begin
          fre_kw <= kw;
          cnt    <= '0;
          if (kw <= RT_KW_MAX) begin
            samp_kw <= sat_shl(kw);
            times   <= 32'd1 << RT_SHIFT;
          end else begin
            samp_kw <= sat_sub(kw, dlt_lat);
            times   <= teqv_lat;
          end
        end
        SETTLE: cnt <= cnt + 32'd1;
        ARM:    cnt <= '0;
        WAIT: begin
          cnt  <= cnt + 32'd1;
          flag <= ~found_rise;
        end
        NEXT: if (idx != n_last) begin
          idx <= idx + IDX_W'(1);
          kw  <= next_kw(kw, step_lat);
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Randomized bench for sweep_sequencer: a detector model answers each re-arm, and every
// result write is compared with a point list computed from the sweep rules.
module tb_sweep_sequencer;

  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 100;
  localparam logic [31:0] RT_MAX  = 32'h0900_0000;
  localparam int unsigned RT_SH   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] kw_start = '0, kw_step = '0, kw_eqv_dlt = '0, times_eqv = '0;
  logic [7:0]  n_points = '0;
  logic [11:0] vpp;
  logic        vpp_found;
  logic [31:0] fre_kw, samp_kw, times;
  logic        vpp_clr, res_we, busy, done;
  logic [7:0]  res_addr;
  logic [12:0] res_data;

  sweep_sequencer #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT), .RT_KW_MAX(RT_MAX),
                    .RT_SHIFT(RT_SH), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .kw_start(kw_start),
    .kw_step(kw_step), .n_points(n_points), .kw_eqv_dlt(kw_eqv_dlt), .times_eqv(times_eqv),
    .vpp(vpp), .vpp_found(vpp_found), .fre_kw(fre_kw), .samp_kw(samp_kw), .times(times),
    .vpp_clr(vpp_clr), .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fre, samp, tms;
    logic [12:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t        expq[$];
  int          plan_dly[256];
  logic [11:0] plan_vpp[256];
  int          sweep_gen = 0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] k, input logic [31:0] s);
`ifdef LOG_SWEEP_EN
    logic [31:0] inc;
    inc = k / (32'd1 << s[4:0]);
    if (inc == 0) inc = 1;
    return k + inc;
`else
    return k + s;
`endif
  endfunction

  // Detector: drops found on re-arm, then answers after a planned delay (or never)
  initial begin
    int k, gen;
    k = 0; gen = 0; vpp_found = 1'b0; vpp = '0;
    forever begin
      @(negedge clk);
      if (gen != sweep_gen) begin gen = sweep_gen; k = 0; end
      if (vpp_clr === 1'b1) begin
        vpp_found = 1'b0;
        if (plan_dly[k] >= 0) begin
          repeat (plan_dly[k]) @(negedge clk);
          vpp = plan_vpp[k];
          @(negedge clk);
          vpp_found = 1'b1;
        end else begin
          vpp = 12'($urandom);
        end
        k++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && res_we === 1'b1) begin
      if (expq.size() == 0) chk("extra_res_we", {56'h0, res_addr}, 64'hFF);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("res_addr", res_addr, e.addr);
        chk("res_data", res_data, e.data);
        chk("fre_kw",   fre_kw,   e.fre);
        chk("samp_kw",  samp_kw,  e.samp);
        chk("times",    times,    e.tms);
      end
    end
  end

  // resp: 0 random, 1 all answer, 2 none answer, 3 only the first answers
  task automatic prepare(input logic [31:0] ks, input logic [31:0] st, input int n,
                         input logic [31:0] dlt, input logic [31:0] teq, input int resp,
                         input int vfix, input int n_push);
    logic [31:0] k;
    logic [63:0] w;
    exp_t e;
    k = ks;
    expq.delete();
    sweep_gen++;
    for (int i = 0; i < n; i++) begin
      case (resp)
        0:       plan_dly[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 50));
        1:       plan_dly[i] = int'($urandom_range(0, 50));
        2:       plan_dly[i] = -1;
        default: plan_dly[i] = (i == 0) ? 5 : -1;
      endcase
      plan_vpp[i] = (vfix >= 0) ? 12'(vfix) : 12'($urandom);
      e.fre  = k;
      e.addr = 8'(i);
      e.data = (plan_dly[i] >= 0) ? {1'b0, plan_vpp[i]} : 13'h1000;
      if (k <= RT_MAX) begin
        w      = 64'(k) * (64'd1 << RT_SH);
        e.samp = (w > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : w[31:0];
        e.tms  = 32'd1 << RT_SH;
      end else begin
        e.samp = (k > dlt) ? k - dlt : 32'h0;
        e.tms  = teq;
      end
      if (i < n_push) expq.push_back(e);
      k = m_next(k, st);
    end
  endtask

  task automatic launch(input logic [31:0] ks, input logic [31:0] st, input int n,
                        input logic [31:0] dlt, input logic [31:0] teq);
    kw_start = ks; kw_step = st; n_points = 8'(n); kw_eqv_dlt = dlt; times_eqv = teq;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (done !== 1'b1 && c < limit) begin @(negedge clk); c++; end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic run_sweep(input logic [31:0] ks, input logic [31:0] st, input int n,
                           input logic [31:0] dlt, input logic [31:0] teq, input int resp,
                           input int vfix, input bit poke);
    prepare(ks, st, n, dlt, teq, resp, vfix, n);
    @(negedge clk);
    launch(ks, st, n, dlt, teq);
    chk("busy_after_start", busy, 1'b1);
    chk("done_cleared", done, 1'b0);
    @(negedge clk);
    chk("first_fre_kw_2cyc", fre_kw, ks);
    if (poke) begin
      repeat (3) @(negedge clk);
      kw_step = st + 7; kw_eqv_dlt = ~dlt; times_eqv = ~teq; n_points = 8'(n + 2);
      launch(~ks, st + 7, n + 2, ~dlt, ~teq);
    end
    wait_done(n * (SETTLE + TIMEOUT + 10) + 20);
    chk("busy_end", busy, 1'b0);
    chk("all_points_written", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nclr, c;
    for (int i = 0; i < 256; i++) begin plan_dly[i] = -1; plan_vpp[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_fre_kw", fre_kw, 0);
    chk("rst_samp_kw", samp_kw, 0);
    chk("rst_times", times, 0);
    chk("rst_flags", {busy, done, vpp_clr, res_we, res_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(100, 50, 3, 0, 0, 1, 12'h123, 0);
    run_sweep(200, 3, 3, 0, 0, 2, -1, 0);
    run_sweep(RT_MAX, 1, 2, 10, 32'd77, 1, -1, 0);
    run_sweep(RT_MAX + 1, 1, 2, 32'hFFFF_FFFF, 32'd9, 1, -1, 0);
    run_sweep(32'h0400_0000, 32'h0400_0000, 3, 5, 32'd11, 0, -1, 0);
    run_sweep(32'hFFFF_FFF0, 32'h20, 2, 5, 32'd3, 1, -1, 0);
    run_sweep(1024, 2, 3, 0, 0, 1, -1, 1);
    run_sweep(1, 2, 3, 0, 0, 0, -1, 0);

    // Zero points: done within two cycles, never busy, no writes
    prepare(0, 0, 0, 0, 0, 1, -1, 0);
    launch(55, 1, 0, 0, 0);
    chk("n0_busy", busy, 1'b0);
    if (done !== 1'b1) @(negedge clk);
    chk("n0_done_2cyc", done, 1'b1);

    // Abort in WAIT of point 1, then a clean full sweep
    prepare(300, 10, 4, 0, 0, 3, -1, 1);
    launch(300, 10, 4, 0, 0);
    nclr = 0; c = 0;
    while (nclr < 2 && c < 1000) begin @(negedge clk); if (vpp_clr) nclr++; c++; end
    chk("abort_reached_arm1", nclr, 2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (150) @(negedge clk);
    chk("abort_no_more_we", expq.size(), 0);
    chk("abort_done_held", done, 1'b0);
    run_sweep(300, 10, 4, 0, 0, 1, -1, 0);

    // Abort has priority over start
    abort = 1'b1;
    launch(5, 1, 2, 0, 0);
    abort = 1'b0;
    chk("abort_over_start", busy, 1'b0);

    // Reset mid-sweep returns outputs to zero at once
    prepare(400, 1, 3, 0, 0, 2, -1, 0);
    launch(400, 1, 3, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fre_kw", fre_kw, 0);
    chk("midrst_samp_kw", samp_kw, 0);
    chk("midrst_status", {busy, done, times}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      logic [31:0] ks, st;
      case ($urandom_range(0, 2))
        0:       begin ks = $urandom_range(0, 1000); st = $urandom_range(0, 5000); end
        1:       begin ks = RT_MAX - 2 + $urandom_range(0, 4); st = $urandom_range(0, 3); end
        default: begin ks = $urandom; st = $urandom; end
      endcase
      run_sweep(ks, st, int'($urandom_range(1, 4)), $urandom, $urandom, 0, -1, t[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
